sumador_secuencial_display: RTL and testbench
=============================================

Name: sumador_secuencial_display

Overview:
- Parametrised successor to the 4-bit adder/7-segment block.
- Adds or subtracts two ANCHO-bit operands nibble-serially, one 4-bit slice per clock, carry chained across cycles.
- Uses a valid/ready handshake and registers the result and flags.
- Drives a time-multiplexed, multi-digit hex 7-segment display of the last completed result; sits between the board switch/button logic and the display pins.

Parameters:
- ANCHO, 8: operand/result width in bits; must be a multiple of 4 and at least 4, otherwise elaboration error.
- DIV_BARRIDO, 50000: clock cycles each digit stays lit; must be at least 1.
- DIGITOS (localparam), ANCHO/4: number of hex digits.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inicio  in  1  request valid; operands and modo sampled when inicio && listo.
- listo  out  1  ready; block accepts a new operation.
- modo  in  1  0 = X+Y, 1 = X−Y.
- X  in  ANCHO  operand A.
- Y  in  ANCHO  operand B.
- resultado  out  ANCHO  last completed result (registered).
- acarreo  out  1  carry out; in subtract mode 1 = no borrow.
- desbordamiento  out  1  two's-complement overflow of last result.
- valido  out  1  one-cycle pulse when resultado/flags update.
- segmentos  out  7  active-low segments, bit0 = a … bit6 = g.
- anodos  out  DIGITOS  active-low one-hot digit enable.

Behaviour:
- Reset state (async on rst, held while high):
  - FSM = ESPERA, listo = 1, valido = 0.
  - resultado = 0, acarreo = 0, desbordamiento = 0.
  - Nibble index = 0, scan prescaler = 0, digit index = 0.
  - anodos = all 1 except bit0 = 0; segmentos = 7'b1000000 (glyph '0').
- FSM ESPERA:
  - listo = 1.
  - On inicio && listo, latch X into opA, latch (modo ? ~Y : Y) into opB, set carry register = modo, nibble index = 0, then go to SUMANDO.
- FSM SUMANDO:
  - listo = 0; inicio is ignored.
  - Each cycle, add nibble k of opA and opB plus the carry register; write the sum into working-result nibble k; update the carry register; k++.
  - On the edge that processes k = DIGITOS−1, load resultado from the working result, acarreo from the final carry, and desbordamiento from (carry into MSB) XOR (carry out). Assert valido for exactly that next cycle and return to ESPERA.
- Latency: acceptance edge E0; valido high in the cycle after edge E(DIGITOS); listo high again in the same cycle.
- Back-to-back: inicio asserted during the valido cycle is accepted; throughput is one operation per DIGITOS+1 cycles.
- Display:
  - Shows the registered resultado only; during SUMANDO it shows the previous value, never partial nibbles.
  - Prescaler counts 0..DIV_BARRIDO−1. On wrap, digit index advances and wraps from DIGITOS−1 to 0.
  - anodos = ~(1 << digit index); segmentos = hex glyph of resultado nibble [digit index].
  - segmentos and anodos change on the same edge (registered), so there is no ghosting.
- Mid-operation reset: the operation is abandoned, no valido pulse, and the outputs take their reset values.
- DIGITOS = 1 case: SUMANDO lasts exactly one cycle; the display never scans; anodos constant 0.

Optional Feature:
- Macro SUPRIME_CEROS_EN: leading-zero blanking.
- When defined: any digit above the most-significant non-zero nibble of resultado has its anode driven 1 (dark) during its scan slot. Digit 0 is always lit, so value 0 shows a single '0'. Blanking mask is computed from the registered resultado.
- When undefined: every digit is lit in its slot, including leading zeros.

Decomposition:
- Package sumador_pkg:
  - FSM state enum (ESPERA, SUMANDO).
  - NIBBLE = 4.
  - 16-entry active-low glyph constant table for 0–F.
  - Reset glyph constant SEG_CERO = 7'b1000000.
- Natural sub-module: decodificador_hex_7seg, purely combinational, 4-bit nibble in, 7-bit active-low segments out, table taken from the package.
- Nibble adder stays inline as a 5-bit add.

Test Plan (ANCHO=8, DIV_BARRIDO=4 unless noted):
- Reset: pulse rst asynchronously between edges → listo=1, valido=0, resultado=0x00, anodos=2'b10, segmentos=7'b1000000 immediately.
- Add: X=0x3C, Y=0x0F, modo=0, one-cycle inicio → listo low 2 cycles, valido pulse 1 cycle, resultado=0x4B, acarreo=0, desbordamiento=0.
- Edges:
  - 0xFF+0x01 → 0x00, acarreo=1, desb=0.
  - 0x7F+0x01 → 0x80, acarreo=0, desb=1.
  - modo=1, 0x05−0x07 → 0xFE, acarreo=0, desb=0.
- Scan: with resultado=0x4B, anodos alternate 10/01 every 4 cycles; segmentos=7'b0000011 ('b') on digit 0 and 7'b0011001 ('4') on digit 1. With SUPRIME_CEROS_EN and result 0x05, digit 1 stays dark.
- Handshake: inicio held during SUMANDO with changing X → ignored. inicio in the valido cycle → second operation accepted, second valido 3 cycles after the first.
- Reset mid-op: rst asserted in the SUMANDO cycle → no valido; resultado keeps 0; the next operation completes normally.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor with hex display:
// FSM state type, nibble width and the active-low 7-segment glyph table.
package sumador_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic {
        ESPERA  = 1'b0,
        SUMANDO = 1'b1
    } estado_t;

    // Active-low segments, bit0 = a ... bit6 = g, index = hex value.
    localparam logic [6:0] GLIFOS [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam logic [6:0] SEG_CERO = 7'b1000000;

endpackage

// File: rtl/sumador_secuencial_display_decodificador_hex_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module decodificador_hex_7seg
    import sumador_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    assign segmentos = GLIFOS[nibble];

endmodule

// File: rtl/sumador_secuencial_display.sv
// Nibble-serial ANCHO-bit adder/subtractor with valid/ready handshake and a
// time-multiplexed hex 7-segment display of the last completed result.
// Optional build macro SUPRIME_CEROS_EN: blank leading-zero digits.
module sumador_secuencial_display
    import sumador_pkg::*;
#(
    parameter int ANCHO       = 8,
    parameter int DIV_BARRIDO = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inicio,
    output logic               listo,
    input  logic               modo,
    input  logic [ANCHO-1:0]   X,
    input  logic [ANCHO-1:0]   Y,
    output logic [ANCHO-1:0]   resultado,
    output logic               acarreo,
    output logic               desbordamiento,
    output logic               valido,
    output logic [6:0]         segmentos,
    output logic [ANCHO/4-1:0] anodos
);

    localparam int DIGITOS = ANCHO / NIBBLE;
    localparam int IW      = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int PW      = (DIV_BARRIDO > 1) ? $clog2(DIV_BARRIDO) : 1;
    localparam logic [IW-1:0] ULTIMO   = IW'(DIGITOS - 1);
    localparam logic [PW-1:0] PRESC_FIN = PW'(DIV_BARRIDO - 1);

    generate
        if (ANCHO < NIBBLE || (ANCHO % NIBBLE) != 0) begin : g_err_ancho
            $error("ANCHO must be a multiple of 4 and at least 4");
        end
        if (DIV_BARRIDO < 1) begin : g_err_div
            $error("DIV_BARRIDO must be at least 1");
        end
    endgenerate

    estado_t          estado;
    logic [ANCHO-1:0] op_a, op_b, trabajo, trabajo_sig;
    logic             carry;
    logic [IW-1:0]    k;
    logic [3:0]       nib_a, nib_b;
    logic [4:0]       suma;
    logic [3:0]       suma_baja;
    logic             c_msb;

    assign listo = (estado == ESPERA);

    // One nibble slice of the add; the low 3-bit partial gives the carry into bit 3.
    always_comb begin
        nib_a       = op_a[int'(k)*NIBBLE +: NIBBLE];
        nib_b       = op_b[int'(k)*NIBBLE +: NIBBLE];
        suma        = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry};
        suma_baja   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry};
        c_msb       = suma_baja[3];
        trabajo_sig = trabajo;
        trabajo_sig[int'(k)*NIBBLE +: NIBBLE] = suma[3:0];
    end

    // Handshake FSM: latch operands, chain carry nibble by nibble, publish on last slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado         <= ESPERA;
            op_a           <= '0;
            op_b           <= '0;
            trabajo        <= '0;
            carry          <= 1'b0;
            k              <= '0;
            resultado      <= '0;
            acarreo        <= 1'b0;
            desbordamiento <= 1'b0;
            valido         <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (inicio) begin
                        op_a   <= X;
                        op_b   <= modo ? ~Y : Y;
                        carry  <= modo;
                        k      <= '0;
                        estado <= SUMANDO;
                    end
                end
                SUMANDO: begin
                    trabajo <= trabajo_sig;
                    carry   <= suma[4];
                    if (k == ULTIMO) begin
                        resultado      <= trabajo_sig;
                        acarreo        <= suma[4];
                        desbordamiento <= c_msb ^ suma[4];
                        valido         <= 1'b1;
                        estado         <= ESPERA;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

    // ---------------- display ----------------
    logic [PW-1:0]      presc;
    logic [IW-1:0]      digito;
    logic [DIGITOS-1:0] encendido;
    logic [3:0]         nib_disp;
    logic [6:0]         seg_dec;

    assign nib_disp = resultado[int'(digito)*NIBBLE +: NIBBLE];

    decodificador_hex_7seg u_dec (
        .nibble    (nib_disp),
        .segmentos (seg_dec)
    );

`ifdef SUPRIME_CEROS_EN
    logic hay_cifra;
    // A digit is lit if it or any higher nibble is non-zero; digit 0 always lit.
    always_comb begin
        encendido = '0;
        hay_cifra = 1'b0;
        for (int d = DIGITOS - 1; d >= 0; d--) begin
            hay_cifra    = hay_cifra | (resultado[d*NIBBLE +: NIBBLE] != 4'h0);
            encendido[d] = hay_cifra || (d == 0);
        end
    end
`else
    assign encendido = '1;
`endif

    // Scan prescaler and digit pointer; anodes and segments registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            digito    <= '0;
            anodos    <= ~DIGITOS'(1);
            segmentos <= SEG_CERO;
        end else begin
            if (presc == PRESC_FIN) begin
                presc  <= '0;
                digito <= (digito == ULTIMO) ? '0 : digito + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            anodos    <= ~(DIGITOS'(1) << digito) | ~encendido;
            segmentos <= seg_dec;
        end
    end

endmodule

// File: tb/tb_sumador_secuencial_display.sv
// Randomized self-checking bench for sumador_secuencial_display (ANCHO=8, DIV_BARRIDO=4).
module tb_sumador_secuencial_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inicio = 1'b0;
    logic       modo = 1'b0;
    logic [7:0] X = 8'h00, Y = 8'h00;
    logic       listo, acarreo, desbordamiento, valido;
    logic [7:0] resultado;
    logic [6:0] segmentos;
    logic [1:0] anodos;

    int checks = 0;
    int errors = 0;

    sumador_secuencial_display #(.ANCHO(8), .DIV_BARRIDO(4)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .listo(listo), .modo(modo),
        .X(X), .Y(Y), .resultado(resultado), .acarreo(acarreo),
        .desbordamiento(desbordamiento), .valido(valido),
        .segmentos(segmentos), .anodos(anodos)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: plain integer add/subtract, signed range for overflow.
    function automatic void modelo(input logic [7:0] a, input logic [7:0] b, input logic m,
                                   output logic [7:0] r, output logic c, output logic v);
        int sa, sb, s, u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = m ? sa - sb : sa + sb;
        u  = m ? int'(a) - int'(b) : int'(a) + int'(b);
        r  = u[7:0];
        c  = m ? (a >= b) : (u > 255);
        v  = (s < -128) || (s > 127);
    endfunction

    function automatic logic [6:0] glifo(input logic [3:0] n);
        case (n)
            4'h0: glifo = 7'b1000000;  4'h1: glifo = 7'b1111001;
            4'h2: glifo = 7'b0100100;  4'h3: glifo = 7'b0110000;
            4'h4: glifo = 7'b0011001;  4'h5: glifo = 7'b0010010;
            4'h6: glifo = 7'b0000010;  4'h7: glifo = 7'b1111000;
            4'h8: glifo = 7'b0000000;  4'h9: glifo = 7'b0010000;
            4'hA: glifo = 7'b0001000;  4'hB: glifo = 7'b0000011;
            4'hC: glifo = 7'b1000110;  4'hD: glifo = 7'b0100001;
            4'hE: glifo = 7'b0000110;  default: glifo = 7'b0001110;
        endcase
    endfunction

    // Issue one operation; returns negedges until valido (0 = timed out) and listo-low count.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          output int lat, output int bajos);
        lat = 0;
        bajos = 0;
        @(negedge clk);
        X = a; Y = b; modo = m; inicio = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) inicio = 1'b0;
            if (valido) begin
                lat = i;
                break;
            end
            if (!listo) bajos++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (listo !== 1'b1) begin errors++; $display("FAIL reset_listo got %b exp 1", listo); end
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido got %b exp 0", valido); end
        checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL reset_resultado got %h exp 00", resultado); end
        checks++; if ({acarreo, desbordamiento} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {acarreo, desbordamiento}); end
        checks++; if (anodos !== 2'b10) begin errors++; $display("FAIL reset_anodos got %b exp 10", anodos); end
        checks++; if (segmentos !== 7'b1000000) begin errors++; $display("FAIL reset_segmentos got %b exp 1000000", segmentos); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [7:0] va [12];
        logic [7:0] vb [12];
        logic       vm [12];
        logic [7:0] er;
        logic       ec, ev;
        int lat, bajos;
        va[0] = 8'h3C; vb[0] = 8'h0F; vm[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; vm[1] = 1'b0;
        va[2] = 8'h7F; vb[2] = 8'h01; vm[2] = 1'b0;
        va[3] = 8'h05; vb[3] = 8'h07; vm[3] = 1'b1;
        for (int i = 4; i < 12; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vm[i] = 1'($urandom);
        end
        for (int i = 0; i < 12; i++) begin
            modelo(va[i], vb[i], vm[i], er, ec, ev);
            run_op(va[i], vb[i], vm[i], lat, bajos);
            checks++; if (lat != 3) begin errors++; $display("FAIL op%0d_latency got %0d exp 3", i, lat); end
            checks++; if (bajos != 2) begin errors++; $display("FAIL op%0d_listo_low got %0d exp 2", i, bajos); end
            checks++; if (resultado !== er) begin errors++; $display("FAIL op%0d_resultado %h %s %h got %h exp %h", i, va[i], vm[i] ? "-" : "+", vb[i], resultado, er); end
            checks++; if (acarreo !== ec) begin errors++; $display("FAIL op%0d_acarreo got %b exp %b", i, acarreo, ec); end
            checks++; if (desbordamiento !== ev) begin errors++; $display("FAIL op%0d_desb got %b exp %b", i, desbordamiento, ev); end
            checks++; if (listo !== 1'b1) begin errors++; $display("FAIL op%0d_listo_back got %b exp 1", i, listo); end
            @(negedge clk);
            checks++; if (valido !== 1'b0) begin errors++; $display("FAIL op%0d_valido_width got %b exp 0", i, valido); end
        end
    endtask

    task automatic test_scan();
        int lat, bajos;
        logic [1:0] prev, exp_an;
        logic       found;
        run_op(8'h3C, 8'h0F, 1'b0, lat, bajos);
        checks++; if (resultado !== 8'h4B) begin errors++; $display("FAIL scan_setup got %h exp 4B", resultado); end
        found = 1'b0;
        @(negedge clk);
        prev = anodos;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (anodos !== prev) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL scan_transition got none exp within 12 cycles"); end
        exp_an = anodos;
        checks++; if (exp_an !== 2'b10 && exp_an !== 2'b01) begin errors++; $display("FAIL scan_onehot got %b exp 10 or 01", exp_an); end
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4; j++) begin
                checks++; if (anodos !== exp_an) begin errors++; $display("FAIL scan_anodos p%0d c%0d got %b exp %b", p, j, anodos, exp_an); end
                checks++; if (segmentos !== glifo(exp_an == 2'b10 ? 4'hB : 4'h4)) begin errors++; $display("FAIL scan_segmentos p%0d c%0d got %b exp %b", p, j, segmentos, glifo(exp_an == 2'b10 ? 4'hB : 4'h4)); end
                @(negedge clk);
            end
            exp_an = ~exp_an;
        end
`ifdef SUPRIME_CEROS_EN
        begin
            int oscuro;
            oscuro = 0;
            run_op(8'h00, 8'h05, 1'b0, lat, bajos);
            @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checks++; if (anodos !== 2'b10 && anodos !== 2'b11) begin errors++; $display("FAIL blank_anodos got %b exp 10 or 11", anodos); end
                if (anodos === 2'b11) oscuro++;
            end
            checks++; if (oscuro == 0) begin errors++; $display("FAIL blank_dark_slot got %0d exp >0", oscuro); end
        end
`endif
    endtask

    task automatic test_handshake();
        @(negedge clk);
        X = 8'h10; Y = 8'h20; modo = 1'b0; inicio = 1'b1;
        @(negedge clk);
        X = 8'($urandom); Y = 8'($urandom);
        checks++; if (listo !== 1'b0) begin errors++; $display("FAIL hs_busy got %b exp 0", listo); end
        @(negedge clk);
        X = 8'($urandom); Y = 8'($urandom);
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL hs_early_valido got %b exp 0", valido); end
        @(negedge clk);
        checks++; if (valido !== 1'b1) begin errors++; $display("FAIL hs_first_valido got %b exp 1", valido); end
        checks++; if (resultado !== 8'h30) begin errors++; $display("FAIL hs_ignore_inputs got %h exp 30", resultado); end
        X = 8'h11; Y = 8'h22; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        checks++; if (listo !== 1'b0) begin errors++; $display("FAIL hs_b2b_accept got %b exp 0", listo); end
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL hs_b2b_gap1 got %b exp 0", valido); end
        @(negedge clk);
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL hs_b2b_gap2 got %b exp 0", valido); end
        @(negedge clk);
        checks++; if (valido !== 1'b1) begin errors++; $display("FAIL hs_second_valido got %b exp 1", valido); end
        checks++; if (resultado !== 8'h33) begin errors++; $display("FAIL hs_second_result got %h exp 33", resultado); end
    endtask

    task automatic test_midreset();
        int lat, bajos;
        logic seen;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        X = 8'h12; Y = 8'h34; modo = 1'b0; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (listo !== 1'b1) begin errors++; $display("FAIL midrst_listo got %b exp 1", listo); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valido) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valido got %b exp 0", seen); end
        checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL midrst_resultado got %h exp 00", resultado); end
        run_op(8'h12, 8'h34, 1'b0, lat, bajos);
        checks++; if (lat != 3) begin errors++; $display("FAIL midrst_next_latency got %0d exp 3", lat); end
        checks++; if (resultado !== 8'h46) begin errors++; $display("FAIL midrst_next_result got %h exp 46", resultado); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_scan();
        test_handshake();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
